dmem_ctrl: RTL and testbench
============================

// Module: dmem_ctrl
// PURPOSE
//  Data-memory controller directly downstream of the load/store buffer. Accepts one
//  load/store request at a time, performs it as byte-serial accesses on the 8-bit
//  RAM bus, sign/zero-extends load data and returns a one-cycle completion pulse.
//  The pulse doubles as the CDB broadcast for loads and as the store retire signal.
// PARAMETERS
//  IO_HI_BITS  2'b11  addr[17:16] value marking the memory-mapped IO region
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst_n          in   1   reset, asynchronous, active-low
//  rdy            in   1   global ready; low = freeze
//  rob_clear      in   1   pipeline flush from RoB
//  req_valid      in   1   request present (LSB in_lsb_ready)
//  req_op         in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_type       in   7   `LD_TYPE or `ST_TYPE
//  req_addr       in   32  effective byte address
//  req_data       in   32  store data (low bytes used)
//  req_ready      out  1   controller idle, request accepted this edge if req_valid
//  resp_valid     out  1   one-cycle completion pulse
//  resp_type      out  7   req_type of the completed request
//  resp_data      out  32  extended load value; 0 for stores
//  mem_din        in   8   RAM read byte (valid 1 cycle after mem_a)
//  mem_dout       out  8   RAM write byte
//  mem_a          out  32  RAM byte address
//  mem_wr         out  1   1 = write mem_dout to mem_a this cycle
//  io_buffer_full in   1   UART buffer full; blocks IO-region writes
// BEHAVIOUR
//  Reset (rst_n=0, any time, async): state IDLE; req_ready=1, resp_valid=0, resp_type=0,
//   resp_data=0, mem_a=0, mem_dout=0, mem_wr=0; byte counters 0. Aborts any access.
//  States: IDLE -> LOAD | STORE -> DONE -> IDLE.
//  Size N = 1 (B/BU), 2 (H/HU), 4 (W). Addresses addr+0..addr+N-1, 32-bit wrap, any
//   alignment legal (no misalign trap).
//  IDLE: req_ready=1. Edge t with req_valid&rdy&!rob_clear latches op/type/addr/data,
//   enters LOAD or STORE. req_valid is level; requester drops it once req_ready falls.
//  LOAD: cycles t+1..t+N drive mem_a=addr+k, mem_wr=0; byte k captured from mem_din
//   in cycle t+2+k into bits [8k+7:8k]. After last capture -> DONE.
//   Latency: resp_valid high in cycle t+N+2 (LB t+3, LW t+6).
//  STORE: cycles t+1..t+N drive mem_a=addr+k, mem_dout=data[8k+7:8k], mem_wr=1.
//   If addr[17:16]==IO_HI_BITS and io_buffer_full: hold byte k, mem_wr=0, retry
//   next cycle. Unstalled latency: resp_valid in cycle t+N+1.
//  DONE: resp_valid=1 exactly one cycle, resp_type latched, resp_data = sign- (B/H) or
//   zero-extended (BU/HU) load word, 0 for stores; req_ready=0. Next edge -> IDLE.
//  rdy=0: no state/counter change, mem_wr forced 0, outputs held. A load byte in
//   flight is discarded; on resume the issue pointer rewinds to the capture pointer
//   and that byte is re-read. A DONE pulse is held until rdy returns (counts once).
//  rob_clear: IDLE ignores req_valid that edge; LOAD -> IDLE at once, mem_wr=0, no
//   resp_valid. STORE and DONE-of-store are committed: complete and pulse regardless.
//  Simultaneous rob_clear and accepting edge: request dropped.
//  Outside STORE, mem_wr=0 always; no RAM write ever occurs for a load.
//  Unknown req_op treated as W; unknown req_type treated as load.
// STRUCTURE
//  Shared config.v: `LD_TYPE 7'b0000011, `ST_TYPE 7'b0100011, funct3 size codes,
//   state encoding localparams.
//  Sub-module load_ext (comb.): {op, raw32} -> extended 32-bit value.
//  Remainder: FSM, 3-bit issue/capture counters, 32-bit assembly register.
// TESTING
//  LW addr 0x100, RAM 0x100..0x103 = 78 56 34 12 -> resp_data 0x12345678, resp in t+6.
//  LB 0x200=0x80 -> 0xFFFFFF80; LBU same -> 0x00000080; LHU 0x201 (odd) bytes 34 F2 -> 0x0000F234.
//  SW 0xDEADBEEF @0x1FFFE -> writes EF BE AD DE to 0x1FFFE..0x20001, resp in t+5, resp_data 0.
//  SB 0x30000 with io_buffer_full high 3 cycles -> mem_wr low 3 cycles, then one write, pulse.
//  LW then rob_clear in cycle t+3 -> no resp_valid, IDLE next cycle; SW + rob_clear -> completes.
//  rdy low cycles t+2..t+4 during LH -> same data, latency +3; rst_n low mid-store -> all outputs reset value immediately.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dmem_ctrl_pkg
// Brief    : Shared opcodes, request types, state encoding and the request
//            record used by the data-memory controller.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_ctrl_pkg;

   localparam logic [6:0] c_LD_TYPE = 7'b0000011;
   localparam logic [6:0] c_ST_TYPE = 7'b0100011;

   localparam logic [2:0] c_OP_B  = 3'b000;
   localparam logic [2:0] c_OP_H  = 3'b001;
   localparam logic [2:0] c_OP_W  = 3'b010;
   localparam logic [2:0] c_OP_BU = 3'b100;
   localparam logic [2:0] c_OP_HU = 3'b101;

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_LOAD  = 2'd1;
   localparam logic [1:0] c_ST_STORE = 2'd2;
   localparam logic [1:0] c_ST_DONE  = 2'd3;

   typedef struct packed {
      logic [2:0]  op;
      logic [6:0]  kind;
      logic [31:0] addr;
      logic [31:0] data;
   } req_t;

   // Any funct3 outside the byte/half codes is handled as a full word.
   function automatic logic [2:0] op_size(input logic [2:0] op);
      case (op)
         c_OP_B, c_OP_BU: op_size = 3'd1;
         c_OP_H, c_OP_HU: op_size = 3'd2;
         default:         op_size = 3'd4;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ctrl_load_ext.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl_load_ext
// Brief    : Combinational sign/zero extension of assembled load data.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl_load_ext
   import dmem_ctrl_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] raw,
   output logic [31:0] ext
);

   always_comb begin
      ext = raw;
      case (op)
         c_OP_B:  ext = {{24{raw[7]}}, raw[7:0]};
         c_OP_H:  ext = {{16{raw[15]}}, raw[15:0]};
         c_OP_BU: ext = {24'd0, raw[7:0]};
         c_OP_HU: ext = {16'd0, raw[15:0]};
         default: ext = raw;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ctrl
// Brief    : Data-memory controller; performs one load/store at a time as
//            byte-serial accesses on the 8-bit RAM bus.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter logic [1:0] IO_HI_BITS = 2'b11
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdy,
   input  logic        rob_clear,
   input  logic        req_valid,
   input  logic [2:0]  req_op,
   input  logic [6:0]  req_type,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [6:0]  resp_type,
   output logic [31:0] resp_data,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   logic [1:0]  r_state;
   req_t        r_req;
   logic [2:0]  r_issue;
   logic [2:0]  r_cap;
   logic        r_pend;
   logic        r_rew;
   logic [31:0] r_asm;
   logic [6:0]  r_resp_type;
   logic [31:0] r_resp_data;

   logic [2:0]  w_size;
   logic        w_req_is_store;
   logic        w_io_stall;
   logic [2:0]  w_iss_ptr;
   logic [2:0]  w_bus_ptr;
   logic        w_last_cap;
   logic        w_last_st;
   logic [7:0]  w_store_byte;
   logic [31:0] w_asm_next;
   logic [31:0] w_ext;

   assign w_size         = op_size(r_req.op);
   assign w_req_is_store = (req_type == c_ST_TYPE);
   assign w_io_stall     = (r_req.addr[17:16] == IO_HI_BITS) && io_buffer_full;
   assign w_last_cap     = ((r_cap + 3'd1) == w_size);
   assign w_last_st      = ((r_issue + 3'd1) == w_size);
   assign w_store_byte   = r_req.data[{r_issue[1:0], 3'b000} +: 8];

   // After a freeze the bus was re-reading the oldest uncaptured byte, so the
   // next byte to issue is the one after it.
   assign w_iss_ptr = r_rew ? (r_cap + 3'd1) : r_issue;
   assign w_bus_ptr = rdy ? w_iss_ptr : r_cap;

   always_comb begin
      w_asm_next = r_asm;
      w_asm_next[{r_cap[1:0], 3'b000} +: 8] = mem_din;
   end

   dmem_ctrl_load_ext u_load_ext (
      .op  (r_req.op),
      .raw (w_asm_next),
      .ext (w_ext)
   );

   assign req_ready  = (r_state == c_ST_IDLE);
   assign resp_valid = (r_state == c_ST_DONE);
   assign resp_type  = r_resp_type;
   assign resp_data  = r_resp_data;

   always_comb begin
      mem_a    = 32'd0;
      mem_dout = 8'd0;
      mem_wr   = 1'b0;
      case (r_state)
         c_ST_LOAD: begin
            mem_a = r_req.addr + {29'd0, w_bus_ptr};
         end
         c_ST_STORE: begin
            mem_a    = r_req.addr + {29'd0, r_issue};
            mem_dout = w_store_byte;
            mem_wr   = rdy && !w_io_stall;
         end
         default: begin
            mem_a    = 32'd0;
            mem_dout = 8'd0;
            mem_wr   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_ST_IDLE;
         r_req       <= '0;
         r_issue     <= 3'd0;
         r_cap       <= 3'd0;
         r_pend      <= 1'b0;
         r_rew       <= 1'b0;
         r_asm       <= 32'd0;
         r_resp_type <= 7'd0;
         r_resp_data <= 32'd0;
      end else if (rdy) begin
         case (r_state)
            c_ST_IDLE: begin
               if (req_valid && !rob_clear) begin
                  r_req.op   <= req_op;
                  r_req.kind <= req_type;
                  r_req.addr <= req_addr;
                  r_req.data <= req_data;
                  r_issue    <= 3'd0;
                  r_cap      <= 3'd0;
                  r_pend     <= 1'b0;
                  r_rew      <= 1'b0;
                  r_asm      <= 32'd0;
                  r_state    <= w_req_is_store ? c_ST_STORE : c_ST_LOAD;
               end
            end

            c_ST_LOAD: begin
               r_rew <= 1'b0;
               if (rob_clear) begin
                  r_pend  <= 1'b0;
                  r_state <= c_ST_IDLE;
               end else begin
                  if (w_iss_ptr < w_size) begin
                     r_issue <= w_iss_ptr + 3'd1;
                     r_pend  <= 1'b1;
                  end else begin
                     r_issue <= w_iss_ptr;
                     r_pend  <= 1'b0;
                  end
                  if (r_pend) begin
                     r_asm <= w_asm_next;
                     r_cap <= r_cap + 3'd1;
                     if (w_last_cap) begin
                        r_resp_type <= r_req.kind;
                        r_resp_data <= w_ext;
                        r_state     <= c_ST_DONE;
                     end
                  end
               end
            end

            // Stores are already committed by the RoB, so a flush is ignored.
            c_ST_STORE: begin
               if (!w_io_stall) begin
                  r_issue <= r_issue + 3'd1;
                  if (w_last_st) begin
                     r_resp_type <= r_req.kind;
                     r_resp_data <= 32'd0;
                     r_state     <= c_ST_DONE;
                  end
               end
            end

            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end else if (r_state == c_ST_LOAD) begin
         // Frozen: the bus shows the capture pointer, so its byte arrives next cycle.
         r_pend <= 1'b1;
         r_rew  <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_ctrl
// Brief    : Directed self-checking bench for dmem_ctrl with a 1-cycle RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_ctrl;

   localparam logic [6:0] c_LD = 7'b0000011;
   localparam logic [6:0] c_ST = 7'b0100011;

   logic        clk;
   logic        rst_n;
   logic        rdy;
   logic        rob_clear;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [6:0]  req_type;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic        req_ready;
   logic        resp_valid;
   logic [6:0]  resp_type;
   logic [31:0] resp_data;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;

   logic [7:0]  ram [0:262143];
   logic        pl_en;
   logic [17:0] pl_addr;
   logic [7:0]  pl_data;
   int          n_wr;
   int          cyc;
   int          t_acc;
   int          n_tests;
   int          n_fail;

   dmem_ctrl #(.IO_HI_BITS(2'b11)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rdy            (rdy),
      .rob_clear      (rob_clear),
      .req_valid      (req_valid),
      .req_op         (req_op),
      .req_type       (req_type),
      .req_addr       (req_addr),
      .req_data       (req_data),
      .req_ready      (req_ready),
      .resp_valid     (resp_valid),
      .resp_type      (resp_type),
      .resp_data      (resp_data),
      .mem_din        (mem_din),
      .mem_dout       (mem_dout),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .io_buffer_full (io_buffer_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      cyc  = 0;
      n_wr = 0;
   end

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      mem_din <= ram[mem_a[17:0]];
      if (pl_en) begin
         ram[pl_addr] <= pl_data;
      end else if (mem_wr) begin
         ram[mem_a[17:0]] <= mem_dout;
         n_wr <= n_wr + 1;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic poke(input logic [17:0] a, input logic [7:0] d);
      pl_addr = a;
      pl_data = d;
      pl_en   = 1'b1;
      @(posedge clk);
      #1 pl_en = 1'b0;
   endtask

   // Returns one time unit after the accepting edge, i.e. early in cycle t+1.
   task automatic start_req(input logic [2:0] op, input logic [6:0] kind,
                            input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      req_op    = op;
      req_type  = kind;
      req_addr  = a;
      req_data  = d;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      t_acc     = cyc;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(input string tag, input int exp_lat,
                            input logic [31:0] exp_data, input logic [6:0] exp_type);
      bit seen;
      int lat;
      seen = 1'b0;
      lat  = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            seen = 1'b1;
            lat  = cyc - t_acc + 1;
         end
      end
      check_eq({tag, "_seen"}, {31'd0, seen}, 32'd1);
      if (seen) begin
         check_eq({tag, "_lat"},  lat,                exp_lat);
         check_eq({tag, "_data"}, resp_data,          exp_data);
         check_eq({tag, "_type"}, {25'd0, resp_type}, {25'd0, exp_type});
         @(negedge clk);
         check_eq({tag, "_pulse1"}, {31'd0, resp_valid}, 32'd0);
         check_eq({tag, "_idle"},   {31'd0, req_ready},  32'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr0;
      int cnt;
      n_tests        = 0;
      n_fail         = 0;
      rst_n          = 1'b0;
      rdy            = 1'b1;
      rob_clear      = 1'b0;
      req_valid      = 1'b0;
      req_op         = 3'd0;
      req_type       = 7'd0;
      req_addr       = 32'd0;
      req_data       = 32'd0;
      io_buffer_full = 1'b0;
      pl_en          = 1'b0;
      pl_addr        = 18'd0;
      pl_data        = 8'd0;

      poke(18'h00100, 8'h78);
      poke(18'h00101, 8'h56);
      poke(18'h00102, 8'h34);
      poke(18'h00103, 8'h12);
      poke(18'h00200, 8'h80);
      poke(18'h00201, 8'h34);
      poke(18'h00202, 8'hF2);
      poke(18'h00300, 8'h34);
      poke(18'h00301, 8'h92);

      @(negedge clk);
      check_eq("rst_ready", {31'd0, req_ready},  32'd1);
      check_eq("rst_resp",  {31'd0, resp_valid}, 32'd0);
      check_eq("rst_rtype", {25'd0, resp_type},  32'd0);
      check_eq("rst_rdata", resp_data,           32'd0);
      check_eq("rst_bus",   {mem_a[22:0], mem_dout, mem_wr}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      wr0 = n_wr;
      start_req(3'b010, c_LD, 32'h100, 32'h0);
      check_eq("lw_busy", {31'd0, req_ready}, 32'd0);
      wait_resp("lw", 6, 32'h12345678, c_LD);
      start_req(3'b000, c_LD, 32'h200, 32'h0);
      wait_resp("lb", 3, 32'hFFFFFF80, c_LD);
      start_req(3'b100, c_LD, 32'h200, 32'h0);
      wait_resp("lbu", 3, 32'h00000080, c_LD);
      start_req(3'b101, c_LD, 32'h201, 32'h0);
      wait_resp("lhu_odd", 4, 32'h0000F234, c_LD);
      check_eq("ld_no_write", n_wr - wr0, 32'd0);

      wr0 = n_wr;
      start_req(3'b010, c_ST, 32'h1FFFE, 32'hDEADBEEF);
      wait_resp("sw", 5, 32'h0, c_ST);
      check_eq("sw_nwr", n_wr - wr0, 32'd4);
      check_eq("sw_bytes", {ram[18'h1FFFE], ram[18'h1FFFF], ram[18'h20000], ram[18'h20001]},
               32'hEFBEADDE);

      wr0 = n_wr;
      cnt = 0;
      io_buffer_full = 1'b1;
      start_req(3'b000, c_ST, 32'h30000, 32'h000000A5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         cnt += {31'd0, mem_wr};
      end
      check_eq("io_stall_wr", cnt, 32'd0);
      @(posedge clk);
      #1 io_buffer_full = 1'b0;
      wait_resp("sb_io", 5, 32'h0, c_ST);
      check_eq("sb_io_nwr", n_wr - wr0, 32'd1);
      check_eq("sb_io_byte", {24'd0, ram[18'h30000]}, 32'h000000A5);

      wr0 = n_wr;
      cnt = 0;
      start_req(3'b010, c_LD, 32'h100, 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1 rob_clear = 1'b1;
      @(negedge clk);
      check_eq("lw_clr_busy", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1 rob_clear = 1'b0;
      @(negedge clk);
      check_eq("lw_clr_idle", {31'd0, req_ready}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         cnt += {31'd0, resp_valid};
      end
      check_eq("lw_clr_noresp", cnt, 32'd0);
      check_eq("lw_clr_nowr", n_wr - wr0, 32'd0);

      wr0 = n_wr;
      start_req(3'b010, c_ST, 32'h40, 32'h11223344);
      @(posedge clk);
      #1 rob_clear = 1'b1;
      @(posedge clk);
      #1 rob_clear = 1'b0;
      t_acc = t_acc;
      wait_resp("sw_clr", 5, 32'h0, c_ST);
      check_eq("sw_clr_nwr", n_wr - wr0, 32'd4);
      check_eq("sw_clr_bytes", {ram[18'h40], ram[18'h41], ram[18'h42], ram[18'h43]}, 32'h44332211);

      start_req(3'b001, c_LD, 32'h300, 32'h0);
      @(posedge clk);
      #1 rdy = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1 rdy = 1'b1;
      wait_resp("lh_frz", 7, 32'hFFFF9234, c_LD);

      start_req(3'b010, c_ST, 32'h500, 32'hCAFEF00D);
      #2;
      check_eq("rst_mid_wr_before", {31'd0, mem_wr}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_wr",    {31'd0, mem_wr},    32'd0);
      check_eq("rst_mid_a",     mem_a,              32'd0);
      check_eq("rst_mid_dout",  {24'd0, mem_dout},  32'd0);
      check_eq("rst_mid_ready", {31'd0, req_ready}, 32'd1);
      check_eq("rst_mid_rtype", {25'd0, resp_type}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
